// File: rtl/falafel_multi_input_parser.sv
// Multi-channel request front end: buffers one request per channel, arbitrates round-robin, dispatches by opcode.
// Latency: a request captured at edge t is dispatched to its FIFO or the config register at edge t+1 at the earliest.
// Backpressure: req_rdy_o[c] stays low while channel c holds a request that is not granted this cycle; a full FIFO only stalls channels that target it.
//
// Ports:
//   clk_i, rst_i                   clock; asynchronous active-high reset
//   req_val_i/req_rdy_o/req_data_i per-channel request handshake, channel c at req_data_i[c*DATA_W +: DATA_W]
//   alloc_fifo_*                   alloc FIFO write port (full in, write strobe, payload, source channel out)
//   free_fifo_*                    free FIFO write port (full in, write strobe, payload, source channel out)
//   free_list_ptr_o, cfg_valid_o   configured free-list head pointer and sticky "configured" flag
//   err_o, err_cnt_o               one-cycle pulse per dropped reserved-opcode request, saturating drop count
module falafel_multi_input_parser #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 64,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [NUM_CH-1:0]        req_val_i,
    output logic [NUM_CH-1:0]        req_rdy_o,
    input  logic [NUM_CH*DATA_W-1:0] req_data_i,

    input  logic                     alloc_fifo_full_i,
    output logic                     alloc_fifo_write_o,
    output logic [DATA_W-1:0]        alloc_fifo_din_o,
    output logic [CH_W-1:0]          alloc_fifo_id_o,

    input  logic                     free_fifo_full_i,
    output logic                     free_fifo_write_o,
    output logic [DATA_W-1:0]        free_fifo_din_o,
    output logic [CH_W-1:0]          free_fifo_id_o,

    output logic [DATA_W-1:0]        free_list_ptr_o,
    output logic                     cfg_valid_o,
    output logic                     err_o,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);

    typedef enum logic [1:0] {
        OP_ALLOC = 2'b00,
        OP_FREE  = 2'b01,
        OP_CFG   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam int SUM_W = CH_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]             hold_v_q,    hold_v_d;
    logic [NUM_CH-1:0][DATA_W-1:0] hold_data_q, hold_data_d;
    logic [CH_W-1:0]               rr_ptr_q,    rr_ptr_d;
    logic [DATA_W-1:0]             free_list_ptr_q, free_list_ptr_d;
    logic                          cfg_valid_q, cfg_valid_d;
    logic                          err_q,       err_d;
    logic [ERR_CNT_W-1:0]          err_cnt_q,   err_cnt_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] grant;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_idx;
    logic [SUM_W-1:0]  scan_sum;
    logic [CH_W-1:0]   scan_idx;
    logic [DATA_W-1:0] win_data;
    op_e               win_op;

    // A held channel is eligible when its destination can take the word.
    // Config and reserved never touch a FIFO, so they are always eligible.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hold_v_q[c]) begin
                case (op_e'(hold_data_q[c][DATA_W-1 -: 2]))
                    OP_ALLOC: elig[c] = !alloc_fifo_full_i;
                    OP_FREE:  elig[c] = !free_fifo_full_i;
                    default:  elig[c] = 1'b1;
                endcase
            end
        end
    end

    // Round-robin search starting at rr_ptr_q; the first eligible channel
    // wins. Ineligible channels are simply skipped so a stalled FIFO does
    // not block channels headed elsewhere.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (scan_sum >= SUM_W'(NUM_CH)) begin
                scan_sum = scan_sum - SUM_W'(NUM_CH);
            end
            scan_idx = scan_sum[CH_W-1:0];
            if (!grant_vld && elig[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant[c] = grant_vld && (grant_idx == CH_W'(c));
        end
    end

    assign win_data = hold_data_q[grant_idx];
    assign win_op   = op_e'(win_data[DATA_W-1 -: 2]);

    // A granted channel drains this cycle, so it may be refilled on the
    // same edge and a single channel can stream one request per cycle.
    assign req_rdy_o = ~hold_v_q | grant;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_val_i[c] && req_rdy_o[c]) begin
                hold_v_d[c]    = 1'b1;
                hold_data_d[c] = req_data_i[c*DATA_W +: DATA_W];
            end else if (grant[c]) begin
                hold_v_d[c]    = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    always_comb begin
        free_list_ptr_d = free_list_ptr_q;
        cfg_valid_d     = cfg_valid_q;
        err_d           = 1'b0;
        err_cnt_d       = err_cnt_q;
        if (grant_vld && win_op == OP_CFG) begin
            // The opcode bits are not part of the pointer.
            free_list_ptr_d = {2'b00, win_data[DATA_W-3:0]};
            cfg_valid_d     = 1'b1;
        end
        if (grant_vld && win_op == OP_RSVD) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_v_q        <= '0;
            hold_data_q     <= '0;
            rr_ptr_q        <= '0;
            free_list_ptr_q <= '0;
            cfg_valid_q     <= 1'b0;
            err_q           <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            hold_v_q        <= hold_v_d;
            hold_data_q     <= hold_data_d;
            rr_ptr_q        <= rr_ptr_d;
            free_list_ptr_q <= free_list_ptr_d;
            cfg_valid_q     <= cfg_valid_d;
            err_q           <= err_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: dispatch is combinational from the granted holding register.
    // Payload and ID are driven with the winner even when the strobe is low.
    // ------------------------------------------------------------------
    assign alloc_fifo_write_o = grant_vld && (win_op == OP_ALLOC);
    assign alloc_fifo_din_o   = win_data;
    assign alloc_fifo_id_o    = grant_idx;

    assign free_fifo_write_o  = grant_vld && (win_op == OP_FREE);
    assign free_fifo_din_o    = win_data;
    assign free_fifo_id_o     = grant_idx;

    assign free_list_ptr_o    = free_list_ptr_q;
    assign cfg_valid_o        = cfg_valid_q;
    assign err_o              = err_q;
    assign err_cnt_o          = err_cnt_q;

endmodule

// File: tb/tb_falafel_multi_input_parser.sv
// Scoreboard bench for falafel_multi_input_parser (4 channels, 64-bit words).
// Expected FIFO writes are queued when requests are driven and popped by a negedge monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_falafel_multi_input_parser;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int CH_W   = 2;
    localparam int ECW    = 8;

    localparam logic [1:0] K_ALLOC = 2'b10;
    localparam logic [1:0] K_FREE  = 2'b01;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NUM_CH-1:0]        req_val_i = '0;
    logic [NUM_CH-1:0]        req_rdy_o;
    logic [NUM_CH*DATA_W-1:0] req_data_i = '0;
    logic                     alloc_fifo_full_i = 1'b0;
    logic                     alloc_fifo_write_o;
    logic [DATA_W-1:0]        alloc_fifo_din_o;
    logic [CH_W-1:0]          alloc_fifo_id_o;
    logic                     free_fifo_full_i = 1'b0;
    logic                     free_fifo_write_o;
    logic [DATA_W-1:0]        free_fifo_din_o;
    logic [CH_W-1:0]          free_fifo_id_o;
    logic [DATA_W-1:0]        free_list_ptr_o;
    logic                     cfg_valid_o;
    logic                     err_o;
    logic [ECW-1:0]           err_cnt_o;

    falafel_multi_input_parser #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .ERR_CNT_W(ECW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_data_i(req_data_i),
        .alloc_fifo_full_i(alloc_fifo_full_i), .alloc_fifo_write_o(alloc_fifo_write_o),
        .alloc_fifo_din_o(alloc_fifo_din_o), .alloc_fifo_id_o(alloc_fifo_id_o),
        .free_fifo_full_i(free_fifo_full_i), .free_fifo_write_o(free_fifo_write_o),
        .free_fifo_din_o(free_fifo_din_o), .free_fifo_id_o(free_fifo_id_o),
        .free_list_ptr_o(free_list_ptr_o), .cfg_valid_o(cfg_valid_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] din;
        logic [1:0]  id;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   err_pulses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [1:0] kind, input logic [63:0] din,
                             input logic [1:0] id, input int at_cyc);
        exp_t e;
        e.kind = kind; e.din = din; e.id = id; e.cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (err_o) err_pulses++;
        if (alloc_fifo_write_o || free_fifo_write_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr", {62'd0, alloc_fifo_write_o, free_fifo_write_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wr_kind", {62'd0, alloc_fifo_write_o, free_fifo_write_o}, {62'd0, e.kind});
                if (alloc_fifo_write_o) begin
                    chk("wr_din", alloc_fifo_din_o, e.din);
                    chk("wr_id", 64'(alloc_fifo_id_o), 64'(e.id));
                end else begin
                    chk("wr_din", free_fifo_din_o, e.din);
                    chk("wr_id", 64'(free_fifo_id_o), 64'(e.id));
                end
                if (e.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Hold a request on one channel until it is accepted, then drop valid.
    task automatic push_req(input int ch, input logic [63:0] w);
        req_val_i[ch] = 1'b1;
        req_data_i[ch*DATA_W +: DATA_W] = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (req_rdy_o[ch]) break;
        end
        chk("accept_wait", 64'(req_rdy_o[ch]), 64'd1);
        @(posedge clk_i); #1;
        req_val_i[ch] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rdy",   64'(req_rdy_o), 64'hF);
        chk("rst_awr",   64'(alloc_fifo_write_o), 64'd0);
        chk("rst_fwr",   64'(free_fifo_write_o), 64'd0);
        chk("rst_ptr",   free_list_ptr_o, 64'd0);
        chk("rst_cfgv",  64'(cfg_valid_o), 64'd0);
        chk("rst_err",   64'(err_o), 64'd0);
        chk("rst_errcnt", 64'(err_cnt_o), 64'd0);
        rst_i = 1'b0;

        // ---------------- single alloc on ch0 ----------------
        @(posedge clk_i); #1;
        push_req(0, 64'h0000_0000_0000_0040);
        expect_wr(K_ALLOC, 64'h40, 2'd0, cyc);
        repeat (3) @(posedge clk_i); #1;
        chk("t1_drained", 64'(sb_q.size()), 64'd0);

        // ---------------- 4-way round robin, two rounds ----------------
        do_reset();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk_i); #1;
            req_val_i = '1;
            for (int c = 0; c < NUM_CH; c++)
                req_data_i[c*DATA_W +: DATA_W] = 64'h100 + 64'(r*16 + c);
            @(posedge clk_i); #1;
            req_val_i = '0;
            t = cyc;
            for (int c = 0; c < NUM_CH; c++)
                expect_wr(K_ALLOC, 64'h100 + 64'(r*16 + c), 2'(c), t + c);
            for (int c = 0; c < NUM_CH; c++) begin
                @(negedge clk_i);
                chk("t2_rdy", 64'(req_rdy_o), 64'((1 << (c + 1)) - 1));
            end
        end

        // ---------------- single-channel streaming at full rate ----------------
        @(posedge clk_i); #1;
        for (int k = 0; k < 6; k++) begin
            req_val_i[1] = 1'b1;
            req_data_i[1*DATA_W +: DATA_W] = 64'h200 + 64'(k);
            @(negedge clk_i);
            chk("stream_rdy", 64'(req_rdy_o[1]), 64'd1);
            @(posedge clk_i); #1;
            expect_wr(K_ALLOC, 64'h200 + 64'(k), 2'd1, cyc);
        end
        req_val_i[1] = 1'b0;
        repeat (2) @(posedge clk_i); #1;

        // ---------------- alloc FIFO full: free bypasses stalled alloc ----------------
        alloc_fifo_full_i = 1'b1;
        req_val_i[0] = 1'b1; req_data_i[0*DATA_W +: DATA_W] = 64'h0000_0000_0000_0300;
        req_val_i[1] = 1'b1; req_data_i[1*DATA_W +: DATA_W] = 64'h4000_0000_0000_0301;
        @(posedge clk_i); #1;
        req_val_i = '0;
        expect_wr(K_FREE, 64'h4000_0000_0000_0301, 2'd1, cyc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t3_rdy0_held", 64'(req_rdy_o[0]), 64'd0);
        end
        @(posedge clk_i); #1;
        alloc_fifo_full_i = 1'b0;
        expect_wr(K_ALLOC, 64'h300, 2'd0, cyc);
        @(negedge clk_i);
        chk("t3_rdy0_grant", 64'(req_rdy_o[0]), 64'd1);
        repeat (2) @(posedge clk_i); #1;
        chk("t3_drained", 64'(sb_q.size()), 64'd0);

        // ---------------- config writes ----------------
        push_req(2, 64'h8000_0000_0000_1000);
        @(negedge clk_i);
        chk("cfg_ptr_before", free_list_ptr_o, 64'd0);
        chk("cfg_v_before", 64'(cfg_valid_o), 64'd0);
        @(negedge clk_i);
        chk("cfg_ptr", free_list_ptr_o, 64'h1000);
        chk("cfg_v", 64'(cfg_valid_o), 64'd1);
        @(posedge clk_i); #1;
        push_req(0, 64'hBFFF_FFFF_FFFF_FFFF);
        repeat (2) @(negedge clk_i);
        chk("cfg_ptr_mask", free_list_ptr_o, 64'h3FFF_FFFF_FFFF_FFFF);

        // ---------------- 300 reserved requests: pulses and saturation ----------------
        @(posedge clk_i); #1;
        base = err_pulses;
        for (int k = 0; k < 300; k++) begin
            req_val_i[3] = 1'b1;
            req_data_i[3*DATA_W +: DATA_W] = 64'hC000_0000_0000_0000 + 64'(k);
            @(posedge clk_i); #1;
            if (k == 9) begin
                @(negedge clk_i);
                chk("err_cnt_mid", 64'(err_cnt_o), 64'd9);
                @(posedge clk_i); #1;
                // one extra cycle of the same word: counts as request 11
                k++;
                req_data_i[3*DATA_W +: DATA_W] = 64'hC000_0000_0000_0000 + 64'(k);
            end
        end
        req_val_i[3] = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        chk("err_pulses", 64'(err_pulses - base), 64'd300);
        chk("err_cnt_sat", 64'(err_cnt_o), 64'd255);
        chk("err_idle", 64'(err_o), 64'd0);

        // ---------------- async reset with three channels held ----------------
        alloc_fifo_full_i = 1'b1;
        free_fifo_full_i  = 1'b1;
        req_val_i = 4'b0111;
        req_data_i[0*DATA_W +: DATA_W] = 64'h0000_0000_0000_0500;
        req_data_i[1*DATA_W +: DATA_W] = 64'h4000_0000_0000_0501;
        req_data_i[2*DATA_W +: DATA_W] = 64'h0000_0000_0000_0502;
        @(posedge clk_i); #1;
        req_val_i = '0;
        @(negedge clk_i);
        chk("t6_rdy_held", 64'(req_rdy_o), 64'h8);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_rdy", 64'(req_rdy_o), 64'hF);
        chk("t6_rst_awr", 64'(alloc_fifo_write_o), 64'd0);
        chk("t6_rst_fwr", 64'(free_fifo_write_o), 64'd0);
        chk("t6_rst_errcnt", 64'(err_cnt_o), 64'd0);
        chk("t6_rst_cfgv", 64'(cfg_valid_o), 64'd0);
        chk("t6_rst_ptr", free_list_ptr_o, 64'd0);
        alloc_fifo_full_i = 1'b0;
        free_fifo_full_i  = 1'b0;
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("t6_rdy_after", 64'(req_rdy_o), 64'hF);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/falafel_multi_input_parser.md
Name: falafel_multi_input_parser

Overview:
Parametrised successor of the single-channel falafel input parser. Accepts requests from NUM_CH independent requester channels, buffers one request per channel, arbitrates round-robin, decodes the opcode and dispatches to the alloc FIFO, the free FIFO or the config register. Writes are tagged with the source channel ID. Sits between the requester ports and the alloc/free FIFOs in front of the allocator core.

Parameters:
NUM_CH, 4, number of requester channels (>=1)
DATA_W, 64, request/FIFO word width (>=8)
CH_W, $clog2(NUM_CH) min 1, channel ID width
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_val_i  in  NUM_CH  per-channel request valid
req_rdy_o  out  NUM_CH  per-channel ready
req_data_i  in  NUM_CH*DATA_W  per-channel request word; channel c at [c*DATA_W +: DATA_W]
alloc_fifo_full_i  in  1  alloc FIFO full
alloc_fifo_write_o  out  1  alloc FIFO write strobe
alloc_fifo_din_o  out  DATA_W  alloc payload
alloc_fifo_id_o  out  CH_W  source channel of alloc write
free_fifo_full_i  in  1  free FIFO full
free_fifo_write_o  out  1  free FIFO write strobe
free_fifo_din_o  out  DATA_W  free payload
free_fifo_id_o  out  CH_W  source channel of free write
free_list_ptr_o  out  DATA_W  configured free-list head pointer
cfg_valid_o  out  1  high once any config write has occurred
err_o  out  1  one-cycle pulse on dropped reserved-opcode request
err_cnt_o  out  ERR_CNT_W  saturating count of dropped requests

Behaviour:
- Opcode = req word [DATA_W-1:DATA_W-2]: 00 alloc, 01 free, 10 config, 11 reserved. Payload = full word, forwarded unmodified.
- Per-channel holding register (valid bit + data). req_rdy_o[c] = !hold_v[c] || grant[c] (same-cycle drain-and-refill allowed). Accept on req_val_i[c] && req_rdy_o[c]; captured at clock edge.
- Eligibility of held channel c: alloc needs !alloc_fifo_full_i; free needs !free_fifo_full_i; config and reserved always eligible.
- Arbiter: at most one grant per cycle. Search starts at rr_ptr and wraps at NUM_CH-1 -> 0; first eligible held channel wins. On grant, rr_ptr <= winner+1 (mod NUM_CH); no grant -> rr_ptr unchanged. Ineligible channels are skipped, not blocking others (no head-of-line blocking across channels).
- Dispatch is combinational from the granted holding register: alloc_fifo_write_o = grant && op==00, din/id from winner; same for free with op==01. Strobes never high together. din/id are don't-care when the strobe is low, but are driven with the winner's data.
- Latency: request accepted at edge t is dispatched at edge t+1 earliest (one-cycle buffer); a full-throughput single channel sustains 1 req/cycle.
- Config (10): free_list_ptr_o <= {2'b00, word[DATA_W-3:0]}; cfg_valid_o <= 1 (sticky). Updated at the grant edge, visible the next cycle.
- Reserved (11): dropped. err_o pulses high for the cycle after the grant edge. err_cnt_o increments and saturates at all-ones.
- Full flag deasserting frees stalled channels in the same cycle. Full asserting with no pending grant: the holding register keeps its data, and req_rdy_o for that channel stays low.
- Reset, including mid-operation: all hold_v=0, rr_ptr=0, free_list_ptr_o=0, cfg_valid_o=0, err_o=0, err_cnt_o=0. Write strobes are 0, req_rdy_o is all-ones once reset deasserts, and buffered requests are discarded.
- NUM_CH=1: arbiter degenerates and CH_W=1 with ID always 0. Behaviour otherwise identical.

Test Plan:
- Reset then single alloc on ch0 word 0x0000_0000_0000_0040 -> alloc_fifo_write_o=1 for exactly one cycle, one cycle after acceptance, din=0x40, id=0, free strobe 0.
- All 4 channels present alloc simultaneously, FIFOs never full -> writes in order ch0,ch1,ch2,ch3 on consecutive cycles; next round from rr_ptr=0 again; req_rdy_o low for each held channel until its grant.
- alloc_fifo_full_i=1 with ch0 alloc and ch1 free held -> ch1 dispatched to the free FIFO the next cycle and ch0 held. Deassert full -> ch0 written that cycle.
- Config word 0x8000_0000_0000_1000 on ch2 -> free_list_ptr_o=0x1000 and cfg_valid_o=1 from the next cycle, no FIFO write.
- 300 reserved-opcode requests (0xC000...) -> 300 err_o pulses, and err_cnt_o saturates at 255.
- Assert rst_i asynchronously while 3 channels are held -> all outputs reset immediately, no write strobes, and req_rdy_o=4'b1111 after release.
